// File: rtl/seg_ctrl_pkg.sv
// Shared types and constants for the single-digit 7-segment controller.
package seg_ctrl_pkg;

    typedef enum logic [1:0] {
        ModeIdle = 2'b00,
        ModeRun  = 2'b01,
        ModeSet  = 2'b10
    } mode_e;

    // Segment patterns {g,f,e,d,c,b,a}, active high, indexed by hex digit.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Bits needed for a counter running 0..n-1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_digit_ctrl_if.sv
// Key inputs and display outputs of the digit controller.
interface seg_digit_ctrl_if;

    logic       key_mode_i;
    logic       key_add_i;
    logic [6:0] segment_o;
    logic [3:0] digit_o;
    logic [1:0] mode_o;
    logic       dp_o;

    modport master (
        output key_mode_i,
        output key_add_i,
        input  segment_o,
        input  digit_o,
        input  mode_o,
        input  dp_o
    );

    modport slave (
        input  key_mode_i,
        input  key_add_i,
        output segment_o,
        output digit_o,
        output mode_o,
        output dp_o
    );

endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser, stability-count debouncer and one-cycle press pulse.
module key_debounce
    import seg_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic pulse
);

    localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            pulse_q, pulse_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // The counter only survives while the synced level disagrees with the accepted one.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = ~level_q;
                pulse_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/seg_digit_ctrl.sv
// Digit controller: mode FSM, auto-count prescaler and displayed digit register.
module seg_digit_ctrl
    import seg_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TICK_DIV        = 1000
) (
    input logic              clk,
    input logic              rst,
    seg_digit_ctrl_if.slave  bus
);

    localparam int unsigned TickW = cnt_width(TICK_DIV);
    localparam logic [TickW-1:0] TickMax = TickW'(TICK_DIV - 1);

    logic             mode_pulse, add_pulse;
    mode_e            mode_q, mode_d;
    logic [3:0]       digit_q, digit_d;
    logic [TickW-1:0] presc_q, presc_d;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_mode (
        .clk  (clk),
        .rst  (rst),
        .key  (bus.key_mode_i),
        .pulse(mode_pulse)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_add (
        .clk  (clk),
        .rst  (rst),
        .key  (bus.key_add_i),
        .pulse(add_pulse)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= ModeIdle;
            digit_q <= 4'd0;
            presc_q <= '0;
        end else begin
            mode_q  <= mode_d;
            digit_q <= digit_d;
            presc_q <= presc_d;
        end
    end

    // A mode press always takes priority over an add press in the same cycle.
    always_comb begin
        mode_d  = mode_q;
        digit_d = digit_q;
        presc_d = '0;
        unique case (mode_q)
            ModeIdle: begin
                if (mode_pulse) begin
                    mode_d = ModeRun;
                end
            end
            ModeRun: begin
                if (mode_pulse) begin
                    mode_d = ModeSet;
                end else if (add_pulse) begin
                    digit_d = 4'd0;
                end else if (presc_q == TickMax) begin
                    digit_d = digit_q + 4'd1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            ModeSet: begin
                if (mode_pulse) begin
                    mode_d = ModeIdle;
                end else if (add_pulse) begin
                    digit_d = digit_q + 4'd1;
                end
            end
            default: begin
                mode_d = ModeIdle;
            end
        endcase
    end

    assign bus.digit_o   = digit_q;
    assign bus.mode_o    = mode_q;
    assign bus.segment_o = SEG_LUT[digit_q];
    assign bus.dp_o      = (mode_q == ModeSet);

endmodule

// File: tb/tb_seg_digit_ctrl.sv
// Randomised bench for seg_digit_ctrl against a sample-window reference model.
module tb_seg_digit_ctrl;

    localparam int unsigned Deb  = 4;
    localparam int unsigned Tick = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seg_digit_ctrl_if bus ();

    seg_digit_ctrl #(
        .DEBOUNCE_CYCLES(Deb),
        .TICK_DIV       (Tick)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [6:0] exp_seg [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int checks = 0;
    int errors = 0;

    // Reference: raw key history per clock edge, accepted levels, mode, digit, cycles in RUN.
    logic [15:0] hist_m, hist_a;
    bit          lvl_m, lvl_a, pend_m, pend_a;
    int          m_mode, m_digit, m_age;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        hist_m = '0;
        hist_a = '0;
        lvl_m  = 1'b0;
        lvl_a  = 1'b0;
        pend_m = 1'b0;
        pend_a = 1'b0;
        m_mode  = 0;
        m_digit = 0;
        m_age   = 0;
    endtask

    // Synchronised sample seen at edge n is the raw value from edge n-2; accept after Deb in a row.
    function automatic bit accepted_flip(input logic [15:0] h, input bit lvl);
        for (int k = 2; k < int'(Deb) + 2; k++) begin
            if (h[k] == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge();
        if (rst) begin
            model_clear();
            return;
        end
        hist_m = {hist_m[14:0], bus.key_mode_i};
        hist_a = {hist_a[14:0], bus.key_add_i};
        case (m_mode)
            0: if (pend_m) begin m_mode = 1; m_age = 0; end
            1: begin
                if (pend_m) begin
                    m_mode = 2;
                    m_age  = 0;
                end else if (pend_a) begin
                    m_digit = 0;
                    m_age   = 0;
                end else begin
                    m_age++;
                    if (m_age == int'(Tick)) begin
                        m_age   = 0;
                        m_digit = (m_digit + 1) % 16;
                    end
                end
            end
            default: begin
                if (pend_m) m_mode = 0;
                else if (pend_a) m_digit = (m_digit + 1) % 16;
            end
        endcase
        pend_m = 1'b0;
        pend_a = 1'b0;
        if (accepted_flip(hist_m, lvl_m)) begin
            lvl_m  = ~lvl_m;
            pend_m = lvl_m;
        end
        if (accepted_flip(hist_a, lvl_a)) begin
            lvl_a  = ~lvl_a;
            pend_a = lvl_a;
        end
    endtask

    task automatic compare_all();
        check_eq("digit", 32'(bus.digit_o), 32'(m_digit));
        check_eq("mode", 32'(bus.mode_o), 32'(m_mode));
        check_eq("segment", 32'(bus.segment_o), 32'(exp_seg[m_digit]));
        check_eq("dp", 32'(bus.dp_o), 32'(m_mode == 2));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic press(input bit m, input bit a, input int hold);
        bus.key_mode_i = m;
        bus.key_add_i  = a;
        repeat (hold) step();
        bus.key_mode_i = 1'b0;
        bus.key_add_i  = 1'b0;
        repeat (8) step();
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_digit"}, 32'(bus.digit_o), 32'h0);
        check_eq({tag, "_mode"}, 32'(bus.mode_o), 32'h0);
        check_eq({tag, "_seg"}, 32'(bus.segment_o), 32'h3F);
        check_eq({tag, "_dp"}, 32'(bus.dp_o), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int saved;
        bit saw_wrap;
        bit at_f;
        int n;

        rst            = 1'b1;
        bus.key_mode_i = 1'b0;
        bus.key_add_i  = 1'b0;
        model_clear();
        repeat (3) step();
        check_reset_values("rst");
        rst = 1'b0;
        repeat (20) step();
        check_reset_values("idle20");

        // Short glitches on the mode key
        press(1'b1, 1'b0, 1);
        press(1'b1, 1'b0, 3);
        check_eq("glitch_mode", 32'(bus.mode_o), 32'h0);

        // Held mode key: RUN appears 2 + Deb + 1 edges after the rise
        lat = 0;
        bus.key_mode_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (lat == 0 && bus.mode_o == 2'b01) lat = i;
        end
        bus.key_mode_i = 1'b0;
        check_eq("mode_latency", 32'(lat), 32'd7);

        // Auto count across a full wrap
        saw_wrap = 1'b0;
        for (int i = 0; i < 85; i++) begin
            at_f = (m_digit == 15);
            step();
            if (m_digit == 15) check_eq("seg_at_f", 32'(bus.segment_o), 32'h71);
            if (at_f && m_digit == 0) saw_wrap = 1'b1;
        end
        check_eq("wrap_seen", 32'(saw_wrap), 32'd1);
        check_eq("run_mode", 32'(bus.mode_o), 32'd1);

        // Add press landing on the same edge as a tick
        n = 0;
        while (m_age != 3 && n < 20) begin
            step();
            n++;
        end
        check_eq("age_found", 32'(m_age), 32'd3);
        bus.key_add_i = 1'b1;
        repeat (7) step();
        check_eq("clr_wins", 32'(bus.digit_o), 32'h0);
        bus.key_add_i = 1'b0;
        repeat (4) step();
        check_eq("clr_hold", 32'(bus.digit_o), 32'h0);
        step();
        check_eq("first_tick", 32'(bus.digit_o), 32'h1);

        // SET: bring digit to 0, then three increments
        press(1'b1, 1'b0, $urandom_range(4, 9));
        check_eq("set_mode", 32'(bus.mode_o), 32'd2);
        n = (16 - m_digit) % 16;
        repeat (n) press(1'b0, 1'b1, $urandom_range(4, 9));
        check_eq("set_zero", 32'(bus.digit_o), 32'h0);
        repeat (3) press(1'b0, 1'b1, $urandom_range(4, 9));
        check_eq("set_digit", 32'(bus.digit_o), 32'h3);
        check_eq("set_seg", 32'(bus.segment_o), 32'h4F);
        check_eq("set_dp", 32'(bus.dp_o), 32'h1);

        // IDLE ignores add
        press(1'b1, 1'b0, $urandom_range(4, 9));
        press(1'b0, 1'b1, $urandom_range(4, 9));
        check_eq("idle_add_digit", 32'(bus.digit_o), 32'h3);
        check_eq("idle_add_mode", 32'(bus.mode_o), 32'h0);

        // Simultaneous mode and add in SET
        press(1'b1, 1'b0, $urandom_range(4, 9));
        press(1'b1, 1'b0, $urandom_range(4, 9));
        saved = m_digit;
        press(1'b1, 1'b1, $urandom_range(4, 9));
        check_eq("simul_mode", 32'(bus.mode_o), 32'h0);
        check_eq("simul_digit", 32'(bus.digit_o), 32'(saved));

        // Random key activity, including glitches
        for (int i = 0; i < 60; i++) begin
            bus.key_mode_i = ($urandom_range(0, 3) == 0);
            bus.key_add_i  = $urandom_range(0, 1);
            repeat ($urandom_range(1, 9)) step();
            bus.key_mode_i = 1'b0;
            bus.key_add_i  = 1'b0;
            repeat ($urandom_range(1, 8)) step();
        end

        // Reset mid-debounce with the key still held afterwards
        bus.key_mode_i = 1'b1;
        repeat (2) step();
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check_reset_values("async_rst");
        repeat (3) step();
        rst = 1'b0;
        repeat (10) step();
        check_eq("held_thru_rst", 32'(bus.mode_o), 32'h1);
        bus.key_mode_i = 1'b0;
        repeat (8) step();

        // Reset mid-debounce with the key released during reset
        bus.key_mode_i = 1'b1;
        repeat (2) step();
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check_reset_values("async_rst2");
        bus.key_mode_i = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        repeat (20) step();
        check_eq("released_in_rst", 32'(bus.mode_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
